serial_frame_capture: RTL and testbench



---
 rtl/serial_pkg.sv | 23 ++
 rtl/serial_frame_capture_word_fifo2.sv | 72 +++++++
 rtl/serial_frame_capture.sv | 124 ++++++++++++
 tb/tb_serial_frame_capture.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
// Shared definitions for the serial frame capture slice:
//   - FSM state encodings (HUNT / COLLECT)
//   - default word width and sync pattern
//   - counter-width helper used to size the bit and frame counters
// -----------------------------------------------------------------------------
package serial_pkg;

    localparam logic [0:0] STATE_HUNT    = 1'b0;
    localparam logic [0:0] STATE_COLLECT = 1'b1;

    localparam int         DEFAULT_WIDTH     = 4;
    localparam logic [3:0] DEFAULT_SYNC_WORD = 4'b1010;
    localparam int         DEFAULT_FRAMES    = 3;

    // clog2 clamped to at least one bit so that a counter never
    // collapses to zero width.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_frame_capture_word_fifo2.sv
// -----------------------------------------------------------------------------
// word_fifo2
// Two-entry first-in first-out word buffer with registered storage.
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-low reset (empties the buffer, zeroes data)
//   push  : write din this edge (ignored when full unless a pop also happens)
//   din   : word to write
//   pop   : remove the head entry this edge (ignored when empty)
//   dout  : head entry
//   valid : buffer not empty
//   full  : both entries occupied
// -----------------------------------------------------------------------------
module word_fifo2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_count;

    logic w_pop;
    logic w_push;

    assign w_pop  = pop && (r_count != 2'd0);
    // A full buffer can still take a word when the head leaves on the same edge.
    assign w_push = push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= din;
                    else                 r_tail <= din;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Count unchanged; the new word lands behind whatever remains.
                    if (r_count == 2'd1) begin
                        r_head <= din;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout  = r_head;
    assign valid = (r_count != 2'd0);
    assign full  = (r_count == 2'd2);

endmodule

// File: rtl/serial_frame_capture.sv
// -----------------------------------------------------------------------------
// serial_frame_capture
// Watches the parallel output of an upstream shift register, hunts for a sync
// pattern, then slices the following bit stream into WIDTH-bit words and
// hands them on through a 2-entry valid/ready buffer.
// Ports:
//   clk          : rising-edge clock shared with the shift register
//   rst          : asynchronous active-low reset
//   en           : stream active; dropping it aborts a capture in progress
//   q_in         : parallel word from the shift register (one new bit per clk)
//   dout         : head word of the output buffer
//   dout_valid   : dout holds a valid word
//   dout_ready   : consumer takes dout this cycle when high with dout_valid
//   locked       : high while collecting data words
//   overflow     : sticky flag, a captured word was dropped on a full buffer
//   overflow_clr : clears overflow (a drop on the same edge wins)
// -----------------------------------------------------------------------------
module serial_frame_capture
    import serial_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] SYNC_WORD = WIDTH'(DEFAULT_SYNC_WORD),
    parameter int               FRAMES    = DEFAULT_FRAMES,
    parameter bit               INVERT_IN = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             locked,
    output logic             overflow,
    input  logic             overflow_clr
);

    localparam int BW = cnt_width(WIDTH);
    localparam int FW = cnt_width(FRAMES + 1);

    localparam logic [BW-1:0] LAST_BIT   = BW'(WIDTH - 1);
    localparam logic [FW-1:0] LAST_FRAME = FW'(FRAMES - 1);

    logic [0:0]    r_state;
    logic [BW-1:0] r_bit_cnt;
    logic [FW-1:0] r_frame_cnt;
    logic          r_overflow;

    logic [WIDTH-1:0] w_word;
    logic             w_word_done;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_drop;

    // Optional per-bit inversion of the incoming word.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cond
            assign w_word[gi] = INVERT_IN ? ~q_in[gi] : q_in[gi];
        end
    endgenerate

    // The word boundary falls every WIDTH edges after the sync edge, so the
    // word currently sitting in the shift register is exactly the new data.
    assign w_word_done = (r_state == STATE_COLLECT) && en && (r_bit_cnt == LAST_BIT);
    assign w_push      = w_word_done;
    assign w_pop       = dout_valid && dout_ready;
    assign w_drop      = w_push && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= STATE_HUNT;
            r_bit_cnt   <= '0;
            r_frame_cnt <= '0;
        end else if (r_state == STATE_HUNT) begin
            if (en && (w_word == SYNC_WORD)) begin
                r_state     <= STATE_COLLECT;
                r_bit_cnt   <= '0;
                r_frame_cnt <= '0;
            end
        end else if (!en) begin
            r_state     <= STATE_HUNT;
            r_bit_cnt   <= '0;
            r_frame_cnt <= '0;
        end else if (w_word_done) begin
            r_bit_cnt <= '0;
            if (r_frame_cnt == LAST_FRAME) begin
                r_state     <= STATE_HUNT;
                r_frame_cnt <= '0;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (overflow_clr) begin
            r_overflow <= 1'b0;
        end
    end

    word_fifo2 #(
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (w_word),
        .pop   (w_pop),
        .dout  (dout),
        .valid (dout_valid),
        .full  (w_full)
    );

    assign locked   = (r_state == STATE_COLLECT);
    assign overflow = r_overflow;

endmodule

// File: tb/tb_serial_frame_capture.sv
module tb_serial_frame_capture;

    localparam logic [3:0] SYNC = 4'b1010;
    localparam int         FR_A = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [3:0] q_in = 4'b0000;
    logic       dout_ready = 1'b0;
    logic       overflow_clr = 1'b0;

    logic [3:0] dout_a, dout_b;
    logic       valid_a, valid_b, locked_a, locked_b, ovf_a, ovf_b;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_frame_capture #(
        .WIDTH(4), .SYNC_WORD(4'b1010), .FRAMES(2), .INVERT_IN(1'b0)
    ) dut_a (
        .clk(clk), .rst(rst), .en(en), .q_in(q_in),
        .dout(dout_a), .dout_valid(valid_a), .dout_ready(dout_ready),
        .locked(locked_a), .overflow(ovf_a), .overflow_clr(overflow_clr)
    );

    serial_frame_capture #(
        .WIDTH(4), .SYNC_WORD(4'b1010), .FRAMES(3), .INVERT_IN(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst), .en(en), .q_in(q_in),
        .dout(dout_b), .dout_valid(valid_b), .dout_ready(dout_ready),
        .locked(locked_b), .overflow(ovf_b), .overflow_clr(overflow_clr)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic e, input logic [3:0] q, input logic r, input logic c);
        en = e; q_in = q; dout_ready = r; overflow_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en = 1'b0; q_in = 4'b0000; dout_ready = 1'b0; overflow_clr = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Reference model for the FRAMES=2 instance: a sync edge starts a frame,
    // every 4th edge after it yields a word, the frame ends after FR_A words.
    bit         m_locked;
    int         m_since;
    int         m_words;
    bit         m_ovf;
    logic [3:0] m_q[$];

    task automatic model_edge();
        bit pop;
        bit push;
        bit drop;
        pop  = (m_q.size() != 0) && dout_ready;
        push = 1'b0;
        drop = 1'b0;
        if (!m_locked) begin
            if (en && q_in == SYNC) begin
                m_locked = 1'b1; m_since = 0; m_words = 0;
            end
        end else if (!en) begin
            m_locked = 1'b0;
        end else begin
            m_since++;
            if (m_since % 4 == 0) begin
                push = 1'b1;
                m_words++;
                if (m_words == FR_A) m_locked = 1'b0;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < 2) m_q.push_back(q_in);
            else                drop = 1'b1;
        end
        if (drop)              m_ovf = 1'b1;
        else if (overflow_clr) m_ovf = 1'b0;
    endtask

    typedef struct {
        logic       en;
        logic [3:0] q;
        logic       ready;
        logic       clr;
        logic       exp_locked;
        logic       exp_valid;
        logic [3:0] exp_dout;
        logic       exp_ovf;
    } vec_t;

    vec_t tbl[10];

    initial begin
        // Plan 1: sync then a walking shift-register stream, FRAMES=2.
        tbl[0] = '{1'b1, 4'b1010, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0};
        tbl[1] = '{1'b1, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0};
        tbl[2] = '{1'b1, 4'b1001, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0};
        tbl[3] = '{1'b1, 4'b0011, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0};
        tbl[4] = '{1'b1, 4'b0110, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0110, 1'b0};
        tbl[5] = '{1'b1, 4'b1101, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0};
        tbl[6] = '{1'b1, 4'b1011, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0};
        tbl[7] = '{1'b1, 4'b0110, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0};
        tbl[8] = '{1'b1, 4'b1100, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1100, 1'b0};
        tbl[9] = '{1'b1, 4'b1001, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0};

        // Reset state, checked while rst is still low.
        #3;
        chk1("reset_valid", valid_a, 1'b0);
        chk4("reset_dout", dout_a, 4'b0000);
        chk1("reset_locked", locked_a, 1'b0);
        chk1("reset_ovf", ovf_a, 1'b0);
        do_reset();

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].en, tbl[i].q, tbl[i].ready, tbl[i].clr);
            chk1($sformatf("tbl%0d_locked", i), locked_a, tbl[i].exp_locked);
            chk1($sformatf("tbl%0d_valid", i), valid_a, tbl[i].exp_valid);
            chk1($sformatf("tbl%0d_ovf", i), ovf_a, tbl[i].exp_ovf);
            if (tbl[i].exp_valid) chk4($sformatf("tbl%0d_dout", i), dout_a, tbl[i].exp_dout);
        end

        // Plan 2: no sync pattern ever appears.
        do_reset();
        for (int i = 0; i < 50; i++) begin
            logic [3:0] q;
            q = 4'($urandom_range(15));
            if (q == SYNC) q = 4'b1011;
            step(1'b1, q, 1'b1, 1'b0);
            chk1("nosync_locked", locked_a, 1'b0);
            chk1("nosync_valid", valid_a, 1'b0);
        end

        // Plan 3: FRAMES=3, consumer stalled, third word dropped.
        do_reset();
        step(1'b1, 4'b1010, 1'b0, 1'b0);
        for (int e = 1; e <= 12; e++) begin
            logic [3:0] q;
            q = (e == 4) ? 4'b0001 : (e == 8) ? 4'b0010 : (e == 12) ? 4'b0011 : 4'b0000;
            step(1'b1, q, 1'b0, 1'b0);
            if (e == 8) begin
                chk4("ovf3_dout_e8", dout_b, 4'b0001);
                chk1("ovf3_ovf_e8", ovf_b, 1'b0);
            end
        end
        chk1("ovf3_valid", valid_b, 1'b1);
        chk4("ovf3_head_a", dout_b, 4'b0001);
        chk1("ovf3_ovf", ovf_b, 1'b1);
        chk1("ovf3_locked", locked_b, 1'b0);
        step(1'b0, 4'b0000, 1'b1, 1'b0);
        chk1("drain_valid_b", valid_b, 1'b1);
        chk4("drain_head_b", dout_b, 4'b0010);
        step(1'b0, 4'b0000, 1'b1, 1'b0);
        chk1("drain_empty", valid_b, 1'b0);
        chk1("drain_ovf_sticky", ovf_b, 1'b1);
        step(1'b0, 4'b0000, 1'b0, 1'b1);
        chk1("ovf_clr", ovf_b, 1'b0);

        // Plan 4: full buffer, pop and push on the same edge.
        do_reset();
        step(1'b1, 4'b1010, 1'b0, 1'b0);
        for (int e = 1; e <= 12; e++) begin
            logic [3:0] q;
            q = (e == 4) ? 4'b0001 : (e == 8) ? 4'b0010 : (e == 12) ? 4'b0011 : 4'b0000;
            step(1'b1, q, (e == 12), 1'b0);
        end
        chk1("pp_valid", valid_b, 1'b1);
        chk4("pp_head_b", dout_b, 4'b0010);
        chk1("pp_ovf", ovf_b, 1'b0);
        step(1'b0, 4'b0000, 1'b1, 1'b0);
        chk4("pp_head_c", dout_b, 4'b0011);
        step(1'b0, 4'b0000, 1'b1, 1'b0);
        chk1("pp_empty", valid_b, 1'b0);

        // Plan 5: en drop aborts, re-sync restarts the cadence.
        do_reset();
        step(1'b1, 4'b1010, 1'b1, 1'b0);
        chk1("abort_lock_e0", locked_a, 1'b1);
        step(1'b1, 4'b0000, 1'b1, 1'b0);
        step(1'b0, 4'b0000, 1'b1, 1'b0);
        chk1("abort_unlock_e2", locked_a, 1'b0);
        step(1'b1, 4'b0000, 1'b1, 1'b0);
        step(1'b1, 4'b0000, 1'b1, 1'b0);
        chk1("abort_nopush", valid_a, 1'b0);
        step(1'b1, 4'b1010, 1'b1, 1'b0);
        chk1("resync_lock_e5", locked_a, 1'b1);
        for (int e = 6; e <= 8; e++) step(1'b1, 4'b0000, 1'b1, 1'b0);
        chk1("resync_e8_empty", valid_a, 1'b0);
        step(1'b1, 4'b0111, 1'b1, 1'b0);
        chk1("resync_e9_valid", valid_a, 1'b1);
        chk4("resync_e9_dout", dout_a, 4'b0111);

        // Plan 6: asynchronous reset mid-frame with data and overflow pending.
        do_reset();
        for (int e = 0; e <= 14; e++) begin
            logic [3:0] q;
            case (e)
                0, 9:    q = 4'b1010;
                4:       q = 4'b0101;
                8:       q = 4'b0110;
                13:      q = 4'b0111;
                default: q = 4'b0000;
            endcase
            step(1'b1, q, 1'b0, 1'b0);
        end
        chk1("pre_arst_valid", valid_a, 1'b1);
        chk1("pre_arst_locked", locked_a, 1'b1);
        chk1("pre_arst_ovf", ovf_a, 1'b1);
        #3;
        rst = 1'b0;
        #1;
        chk1("arst_valid", valid_a, 1'b0);
        chk1("arst_locked", locked_a, 1'b0);
        chk1("arst_ovf", ovf_a, 1'b0);
        chk4("arst_dout", dout_a, 4'b0000);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Randomised run against the reference model (FRAMES=2 instance).
        do_reset();
        m_locked = 1'b0; m_since = 0; m_words = 0; m_ovf = 1'b0;
        m_q.delete();
        for (int i = 0; i < 800; i++) begin
            logic [3:0] q;
            if ($urandom_range(7) == 0) q = SYNC;
            else                        q = {q_in[2:0], 1'($urandom_range(1))};
            en           = ($urandom_range(15) != 0);
            q_in         = q;
            dout_ready   = ($urandom_range(2) != 0);
            overflow_clr = ($urandom_range(9) == 0);
            model_edge();
            @(posedge clk);
            #1;
            chk1("rnd_locked", locked_a, m_locked);
            chk1("rnd_valid", valid_a, m_q.size() != 0);
            chk1("rnd_ovf", ovf_a, m_ovf);
            if (m_q.size() != 0) chk4("rnd_dout", dout_a, m_q[0]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
